// File: rtl/fcp6_responder.sv
// FCP6 target endpoint: decodes header/data pairs, owns four 8-bit registers, acks writes, serializes reads.
// Optional FCP6_PARITY_EN adds a fifth parity pair to every data phase.
module fcp6_responder #(
  parameter logic [4:0] DEV_ID  = 5'b01100,
  parameter logic [7:0] RST_VAL = 8'h58
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ctrl_in,
  input  logic [1:0] data_in,
  output logic [1:0] data_out,
  output logic       data_oe,
  output logic       ack,
  output logic       busy,
  output logic       parity_err
);

`ifdef FCP6_PARITY_EN
  localparam int CW = 3;
  localparam logic [CW-1:0] LAST_DAT = 3'd4;
  localparam logic [CW-1:0] PAR_IDX  = 3'd3;
`else
  localparam int CW = 2;
  localparam logic [CW-1:0] LAST_DAT = 2'd3;
`endif
  localparam logic [CW-1:0] LAST_HDR = CW'(3);

  typedef enum logic [2:0] {IDLE, HDR, ACK_H, WR_DATA, ACK_W, RD_DATA, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    hdr;
  logic [7:0]    dat;
  logic [7:0]    regs [4];
  logic [7:0]    hdr_full;

  // hdr keeps only the low six bits; the id is checked on the full byte as the last pair arrives
  assign hdr_full = {hdr, data_in};

`ifdef FCP6_PARITY_EN
  logic perr;
  logic rpar;
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hdr      <= '0;
      dat      <= '0;
      data_out <= 2'b00;
      data_oe  <= 1'b0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= RST_VAL;
`ifdef FCP6_PARITY_EN
      perr     <= 1'b0;
      rpar     <= 1'b0;
`endif
    end else begin
      ack      <= 1'b0;
      data_oe  <= 1'b0;
      data_out <= 2'b00;
`ifdef FCP6_PARITY_EN
      perr     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ctrl_in == 2'b01) begin
            hdr   <= hdr_full[5:0];
            cnt   <= CW'(1);
            state <= HDR;
            busy  <= 1'b1;
          end
        end
        HDR: begin
          if (ctrl_in == 2'b01) begin
            hdr <= hdr_full[5:0];
            cnt <= cnt + 1'b1;
            if (cnt == LAST_HDR) begin
              if (hdr_full[7:3] == DEV_ID) begin
                state <= ACK_H;
                ack   <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end else if (ctrl_in != 2'b00) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ACK_H: begin
          cnt <= '0;
          if (hdr[0]) begin
            state <= WR_DATA;
          end else begin
            // read value is captured here so a concurrent write cannot tear it
            state    <= RD_DATA;
            data_oe  <= 1'b1;
            data_out <= regs[hdr[2:1]][7:6];
            dat      <= {regs[hdr[2:1]][5:0], 2'b00};
`ifdef FCP6_PARITY_EN
            rpar     <= ^regs[hdr[2:1]];
`endif
          end
        end
        WR_DATA: begin
          if (ctrl_in == 2'b10) begin
            dat <= {dat[5:0], data_in};
            cnt <= cnt + 1'b1;
            if (cnt == LAST_DAT) begin
`ifdef FCP6_PARITY_EN
              if (data_in[0] == ^dat) begin
                regs[hdr[2:1]] <= dat;
                ack            <= 1'b1;
                state          <= ACK_W;
              end else begin
                perr  <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
`else
              regs[hdr[2:1]] <= {dat[5:0], data_in};
              ack            <= 1'b1;
              state          <= ACK_W;
`endif
            end
          end else if (ctrl_in != 2'b00) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ACK_W: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        RD_DATA: begin
          if (ctrl_in == 2'b11 || cnt == LAST_DAT) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt     <= cnt + 1'b1;
            data_oe <= 1'b1;
            dat     <= {dat[5:0], 2'b00};
`ifdef FCP6_PARITY_EN
            data_out <= (cnt == PAR_IDX) ? {1'b0, rpar} : dat[7:6];
`else
            data_out <= dat[7:6];
`endif
          end
        end
        DRAIN: begin
          if (ctrl_in == 2'b00) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcp6_responder.sv
// Self-checking bench for fcp6_responder: transaction-level register model, randomized values and stalls.
module tb_fcp6_responder;
  localparam logic [4:0] DEV_ID  = 5'b01100;
  localparam logic [7:0] RST_VAL = 8'h58;
`ifdef FCP6_PARITY_EN
  localparam int NP = 5;
`else
  localparam int NP = 4;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] ctrl_in;
  logic [1:0] data_in;
  logic [1:0] data_out;
  logic       data_oe;
  logic       ack;
  logic       busy;
  logic       parity_err;

  int checks;
  int failures;
  logic [7:0] model [4];

  fcp6_responder #(.DEV_ID(DEV_ID), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .ack(ack), .busy(busy),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame a data byte as the pairs the wire carries: four data pairs, then the parity pair.
  function automatic logic [9:0] frame(input logic [7:0] v);
    return {v, 1'b0, ^v};
  endfunction

  task automatic send_hdr(input logic [7:0] h, input bit stall, input bit exp_ack, input string tag);
    logic e;
    for (int i = 0; i < 4; i++) begin
      if (stall && $urandom_range(0, 3) == 0) begin
        ctrl_in = 2'b00;
        data_in = 2'($urandom);
        tick();
        checks++;
        if (ack !== 1'b0) begin
          failures++;
          $display("FAIL %s_stall_ack got=%b exp=0", tag, ack);
        end
      end
      ctrl_in = 2'b01;
      data_in = h[7-2*i -: 2];
      tick();
      e = exp_ack && (i == 3);
      checks++;
      if (ack !== e || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_pair%0d ack=%b busy=%b exp ack=%b busy=1", tag, i, ack, busy, e);
      end
    end
  endtask

  task automatic write_txn(input logic [1:0] idx, input logic [7:0] v, input bit stall);
    logic [9:0] d;
    logic e;
    d = frame(v);
    send_hdr({DEV_ID, idx, 1'b1}, stall, 1'b1, "wr_hdr");
    ctrl_in = 2'b00;
    tick();
    for (int i = 0; i < NP; i++) begin
      if (stall && $urandom_range(0, 3) == 0) begin
        ctrl_in = 2'b00;
        tick();
        checks++;
        if (ack !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL wr_stall ack=%b busy=%b exp ack=0 busy=1", ack, busy);
        end
      end
      ctrl_in = 2'b10;
      data_in = d[9-2*i -: 2];
      tick();
      e = (i == NP - 1);
      checks++;
      if (ack !== e || parity_err !== 1'b0) begin
        failures++;
        $display("FAIL wr_data%0d ack=%b perr=%b exp ack=%b perr=0", i, ack, parity_err, e);
      end
    end
    ctrl_in = 2'b00;
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      failures++;
      $display("FAIL wr_done busy=%b ack=%b exp 0 0", busy, ack);
    end
    model[idx] = v;
  endtask

  task automatic read_txn(input logic [1:0] idx, input bit stall);
    logic [9:0] d;
    d = frame(model[idx]);
    send_hdr({DEV_ID, idx, 1'b0}, stall, 1'b1, "rd_hdr");
    ctrl_in = 2'($urandom_range(0, 2));
    tick();
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (data_oe !== 1'b1 || data_out !== d[9-2*i -: 2]) begin
        failures++;
        $display("FAIL rd_reg%0d_pair%0d oe=%b out=%b exp oe=1 out=%b", idx, i, data_oe, data_out, d[9-2*i -: 2]);
      end
      ctrl_in = 2'($urandom_range(0, 2));
      data_in = 2'($urandom);
      tick();
    end
    checks++;
    if (data_oe !== 1'b0 || data_out !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_done oe=%b out=%b busy=%b exp 0 00 0", data_oe, data_out, busy);
    end
    ctrl_in = 2'b00;
  endtask

  task automatic read_all();
    for (int r = 0; r < 4; r++) read_txn(2'(r), 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ctrl_in = 2'b00;
    tick();
    tick();
    checks++;
    if ({data_out, data_oe, ack, busy, parity_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000", {data_out, data_oe, ack, busy, parity_err});
    end
    rst = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) model[r] = RST_VAL;
    read_all();
  endtask

  task automatic test_mismatch();
    send_hdr(8'h47, 1'b0, 1'b0, "mm_hdr");
    for (int i = 0; i < 4; i++) begin
      ctrl_in = 2'b10;
      data_in = 2'b11;
      tick();
      checks++;
      if (ack !== 1'b0 || busy !== 1'b1 || data_oe !== 1'b0) begin
        failures++;
        $display("FAIL mm_drain ack=%b busy=%b oe=%b exp 0 1 0", ack, busy, data_oe);
      end
    end
    ctrl_in = 2'b00;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mm_exit busy=%b exp=0", busy);
    end
    read_all();
  endtask

  task automatic test_write_basic();
    write_txn(2'd3, 8'hA5, 1'b0);
    read_txn(2'd3, 1'b0);
  endtask

  task automatic test_abort();
    send_hdr({DEV_ID, 2'd1, 1'b1}, 1'b0, 1'b1, "ab_hdr");
    ctrl_in = 2'b00;
    tick();
    ctrl_in = 2'b10;
    data_in = 2'b00;
    tick();
    data_in = 2'b11;
    tick();
    ctrl_in = 2'b11;
    tick();
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_wr ack=%b busy=%b exp 0 0", ack, busy);
    end
    ctrl_in = 2'b01;
    data_in = 2'b01;
    tick();
    tick();
    ctrl_in = 2'b10;
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_hdr busy=%b ack=%b exp 0 0", busy, ack);
    end
    ctrl_in = 2'b00;
    tick();
    read_txn(2'd1, 1'b0);
    write_txn(2'd1, 8'h3C, 1'b0);
    read_txn(2'd1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) write_txn(2'($urandom), 8'($urandom), 1'b1);
      else read_txn(2'($urandom), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    write_txn(2'd0, 8'h0F, 1'b0);
    write_txn(2'd2, 8'hE1, 1'b0);
    read_txn(2'd0, 1'b0);
    read_txn(2'd2, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    logic [9:0] d;
    d = frame(model[3]);
    send_hdr({DEV_ID, 2'd3, 1'b0}, 1'b0, 1'b1, "rr_hdr");
    ctrl_in = 2'b00;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (data_oe !== 1'b1 || data_out !== d[9-2*i -: 2]) begin
        failures++;
        $display("FAIL rr_pair%0d oe=%b out=%b exp oe=1 out=%b", i, data_oe, data_out, d[9-2*i -: 2]);
      end
      if (i < 2) tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({data_out, data_oe, ack, busy, parity_err} !== 6'b0) begin
      failures++;
      $display("FAIL rr_outputs got=%b exp=000000", {data_out, data_oe, ack, busy, parity_err});
    end
    rst = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) model[r] = RST_VAL;
    read_all();
  endtask

`ifdef FCP6_PARITY_EN
  task automatic test_parity();
    logic [9:0] d;
    d = {8'hA5, 2'b01};
    send_hdr({DEV_ID, 2'd2, 1'b1}, 1'b0, 1'b1, "par_hdr");
    ctrl_in = 2'b00;
    tick();
    for (int i = 0; i < 5; i++) begin
      ctrl_in = 2'b10;
      data_in = d[9-2*i -: 2];
      tick();
    end
    checks++;
    if (parity_err !== 1'b1 || ack !== 1'b0) begin
      failures++;
      $display("FAIL par_bad perr=%b ack=%b exp 1 0", parity_err, ack);
    end
    ctrl_in = 2'b00;
    tick();
    checks++;
    if (parity_err !== 1'b0 || ack !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL par_after perr=%b ack=%b busy=%b exp 0 0 0", parity_err, ack, busy);
    end
    read_txn(2'd2, 1'b0);
    write_txn(2'd2, 8'hA5, 1'b0);
    read_txn(2'd2, 1'b0);
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ctrl_in  = 2'b00;
    data_in  = 2'b00;
    test_reset();
    test_mismatch();
    test_write_basic();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef FCP6_PARITY_EN
    test_parity();
`endif
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
